// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 restoring divider.
// The default operand width and the divide-by-zero quotient fill live here.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH = 32;

    // Divide by zero yields an all-ones quotient at any width.
    localparam logic DIV_DBZ_FILL = 1'b1;

endpackage

// File: rtl/axis_seq_divider.sv
// Multi-cycle restoring divider, signed or unsigned, with joint AXI-Stream operand
// acceptance and a one-cycle {quotient, remainder} result pulse WIDTH+1 cycles later.
module axis_seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter bit SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata,
    output logic               m_axis_dout_tvalid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    div_state_e         state_r;
    div_state_e         state_next_s;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   dvsr_mag_r;
    logic [WIDTH-1:0]   dividend_r;
    logic               q_neg_r;
    logic               r_neg_r;
    logic               dbz_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] dout_r;
    logic               dout_vld_r;

    logic               tready_s;
    logic               accept_s;
    logic               last_s;
    logic               dd_neg_s;
    logic               dv_neg_s;
    logic [WIDTH-1:0]   dd_mag_s;
    logic [WIDTH-1:0]   dv_mag_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic [WIDTH-1:0]   quo_next_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    assign tready_s               = (state_r == IDLE) & ~flush & ~reset;
    assign s_axis_dividend_tready = tready_s;
    assign s_axis_divisor_tready  = tready_s;
    assign accept_s               = tready_s & s_axis_dividend_tvalid & s_axis_divisor_tvalid;
    assign last_s                 = (state_r == CALC) && (cnt_r == CNT_ZERO);
    assign m_axis_dout_tdata      = dout_r;
    assign m_axis_dout_tvalid     = dout_vld_r;

    // Operand signs and magnitudes; unsigned mode never negates.
    always_comb begin
        dd_neg_s = SIGNED & s_axis_dividend_tdata[WIDTH-1];
        dv_neg_s = SIGNED & s_axis_divisor_tdata[WIDTH-1];
        if (dd_neg_s) begin
            dd_mag_s = -s_axis_dividend_tdata;
        end else begin
            dd_mag_s = s_axis_dividend_tdata;
        end
        if (dv_neg_s) begin
            dv_mag_s = -s_axis_divisor_tdata;
        end else begin
            dv_mag_s = s_axis_divisor_tdata;
        end
    end

    // One restoring step; the shifted-out quotient MSB is the trial's LSB.
    always_comb begin
        trial_s = {rem_r, quo_r[WIDTH-1]} - {1'b0, dvsr_mag_r};
        if (!trial_s[WIDTH]) begin
            rem_next_s = trial_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
            quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign restoration of the final step, with divide by zero overriding it.
    always_comb begin
        if (dbz_r) begin
            quo_fix_s = {WIDTH{DIV_DBZ_FILL}};
            rem_fix_s = dividend_r;
        end else begin
            quo_fix_s = q_neg_r ? -quo_next_s : quo_next_s;
            rem_fix_s = r_neg_r ? -rem_next_s : rem_next_s;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_next_s = accept_s ? CALC : IDLE;
                CALC:    state_next_s = (cnt_r == CNT_ZERO) ? DONE : CALC;
                DONE:    state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture and iterative datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            quo_r      <= {WIDTH{1'b0}};
            rem_r      <= {WIDTH{1'b0}};
            dvsr_mag_r <= {WIDTH{1'b0}};
            dividend_r <= {WIDTH{1'b0}};
            q_neg_r    <= 1'b0;
            r_neg_r    <= 1'b0;
            dbz_r      <= 1'b0;
            cnt_r      <= CNT_ZERO;
        end else if (accept_s) begin
            quo_r      <= dd_mag_s;
            rem_r      <= {WIDTH{1'b0}};
            dvsr_mag_r <= dv_mag_s;
            dividend_r <= s_axis_dividend_tdata;
            q_neg_r    <= dd_neg_s ^ dv_neg_s;
            r_neg_r    <= dd_neg_s;
            dbz_r      <= (s_axis_divisor_tdata == {WIDTH{1'b0}});
            cnt_r      <= CNT_LOAD;
        end else if (state_r == CALC) begin
            quo_r <= quo_next_s;
            rem_r <= rem_next_s;
            cnt_r <= cnt_r - CNT_ONE;
        end
    end

    // Result register: loaded on the edge into DONE, held until the next result.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_r     <= {(2*WIDTH){1'b0}};
            dout_vld_r <= 1'b0;
        end else begin
            dout_vld_r <= last_s & ~flush;
            if (last_s && !flush) begin
                dout_r <= {quo_fix_s, rem_fix_s};
            end
        end
    end

endmodule

// File: tb/tb_axis_seq_divider.sv
// Scoreboard bench for axis_seq_divider: one unsigned and one signed instance,
// directed corner cases plus random operands checked against plain-arithmetic division.
module tb_axis_seq_divider;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic [31:0] dd_u = 32'd0, dv_u = 32'd0, dd_s = 32'd0, dv_s = 32'd0;
    logic        ddv_u = 1'b0, dvv_u = 1'b0, ddv_s = 1'b0, dvv_s = 1'b0;
    logic        rdd_u, rdv_u, rdd_s, rdv_s;
    logic [63:0] out_u, out_s;
    logic        ov_u, ov_s;

    exp_t q_u[$];
    exp_t q_s[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axis_seq_divider #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset), .flush(flush),
        .s_axis_dividend_tdata(dd_u), .s_axis_dividend_tvalid(ddv_u), .s_axis_dividend_tready(rdd_u),
        .s_axis_divisor_tdata(dv_u), .s_axis_divisor_tvalid(dvv_u), .s_axis_divisor_tready(rdv_u),
        .m_axis_dout_tdata(out_u), .m_axis_dout_tvalid(ov_u)
    );

    axis_seq_divider #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset), .flush(flush),
        .s_axis_dividend_tdata(dd_s), .s_axis_dividend_tvalid(ddv_s), .s_axis_dividend_tready(rdd_s),
        .s_axis_divisor_tdata(dv_s), .s_axis_divisor_tvalid(dvv_s), .s_axis_divisor_tready(rdv_s),
        .m_axis_dout_tdata(out_s), .m_axis_dout_tvalid(ov_s)
    );

    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        longint      al, bl;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sgn) begin
            al = longint'($signed(a));
            bl = longint'($signed(b));
            q  = 32'(al / bl);
            r  = 32'(al % bl);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor for the unsigned instance.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (ov_u) begin
            total++;
            if (q_u.size() == 0) begin
                bad++;
                $display("FAIL u_unexpected: got tvalid data %h at cycle %0d want no result", out_u, cyc);
            end else begin
                e = q_u.pop_front();
                if (out_u !== e.data || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL u_result: got %h at cycle %0d want %h at cycle %0d", out_u, cyc, e.data, e.cyc);
                end
            end
        end
    end

    // Monitor for the signed instance.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (ov_s) begin
            total++;
            if (q_s.size() == 0) begin
                bad++;
                $display("FAIL s_unexpected: got tvalid data %h at cycle %0d want no result", out_s, cyc);
            end else begin
                e = q_s.pop_front();
                if (out_s !== e.data || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL s_result: got %h at cycle %0d want %h at cycle %0d", out_s, cyc, e.data, e.cyc);
                end
            end
        end
    end

    // Handshake from a negedge; returns at the negedge after acceptance with the acceptance cycle.
    task automatic accept(input bit sgn, input logic [31:0] a, input logic [31:0] b, output int t);
        bit done = 1'b0;
        t = -1;
        if (sgn) begin dd_s = a; dv_s = b; ddv_s = 1'b1; dvv_s = 1'b1; end
        else     begin dd_u = a; dv_u = b; ddv_u = 1'b1; dvv_u = 1'b1; end
        for (int k = 0; k < 100 && !done; k++) begin
            #1;
            if (sgn ? (rdd_s & rdv_s) : (rdd_u & rdv_u)) begin
                t = cyc;
                done = 1'b1;
                @(posedge clk);
            end
            @(negedge clk);
        end
        ddv_s = 1'b0; dvv_s = 1'b0; ddv_u = 1'b0; dvv_u = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no acceptance want acceptance within 100 cycles");
        end
    endtask

    task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int   t;
        exp_t e;
        accept(sgn, a, b, t);
        if (t >= 0) begin
            e.data = ref_div(sgn, a, b);
            e.cyc  = t + LAT;
            if (sgn) q_s.push_back(e);
            else     q_u.push_back(e);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 80 && (q_u.size() + q_s.size()) > 0; k++) @(negedge clk);
        if ((q_u.size() + q_s.size()) > 0) begin
            total++;
            bad++;
            $display("FAIL result_timeout: got %0d results outstanding want 0", q_u.size() + q_s.size());
            q_u.delete();
            q_s.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        bit          low_bad;
        bit          sgn;
        logic [31:0] a, b;

        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", 64'({rdd_u, rdv_u, rdd_s, rdv_s}), 64'd0);
        check("reset_tvalid", 64'({ov_u, ov_s}), 64'd0);
        check("reset_tdata_u", out_u, 64'd0);
        check("reset_tdata_s", out_s, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("idle_ready", 64'({rdd_u, rdv_u, rdd_s, rdv_s}), 64'hF);
        @(negedge clk);

        // 100/7 unsigned with tready held low through CALC and DONE.
        accept(1'b0, 32'd100, 32'd7, t);
        q_u.push_back('{data: ref_div(1'b0, 32'd100, 32'd7), cyc: t + LAT});
        low_bad = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            #1;
            if (rdd_u | rdv_u) low_bad = 1'b1;
            @(negedge clk);
        end
        check("busy_ready_low", 64'(low_bad), 64'd0);
        #1;
        check("ready_after_done", 64'({rdd_u, rdv_u}), 64'd3);
        check("u_100_7_data", out_u, {32'h0000_000E, 32'h0000_0002});
        @(negedge clk);

        issue(1'b1, 32'hFFFF_FFF9, 32'd2);          wait_idle();
        issue(1'b1, 32'd7, 32'hFFFF_FFFE);          wait_idle();
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);  wait_idle();
        check("s_min_neg1_data", out_s, {32'h8000_0000, 32'h0000_0000});
        issue(1'b0, 32'hFFFF_FFFF, 32'd1);          wait_idle();
        issue(1'b0, 32'd5, 32'd0);                  wait_idle();
        check("u_dbz_data", out_u, {32'hFFFF_FFFF, 32'h0000_0005});
        issue(1'b1, 32'hFFFF_FFFB, 32'd0);          wait_idle();
        check("s_dbz_data", out_s, {32'hFFFF_FFFF, 32'hFFFF_FFFB});
        @(negedge clk);

        // Flush mid-CALC, then a new operation in the very next cycle.
        accept(1'b0, 32'd100, 32'd7, t);
        while (cyc != t + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("ready_after_flush", 64'({rdd_u, rdv_u}), 64'd3);
        check("flush_cycle", 64'(cyc), 64'(t + 11));
        issue(1'b0, 32'd9, 32'd4);
        wait_idle();
        check("u_9_4_data", out_u, {32'h0000_0002, 32'h0000_0001});

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        flush = 1'b1;
        ddv_u = 1'b1; dvv_u = 1'b1;
        #1;
        check("flush_idle_ready", 64'({rdd_u, rdv_u}), 64'd0);
        @(negedge clk);
        flush = 1'b0; ddv_u = 1'b0; dvv_u = 1'b0;
        #1;
        check("no_accept_under_flush", 64'({rdd_u, rdv_u}), 64'd3);
        @(negedge clk);

        // Dividend alone must not be accepted.
        dd_u = 32'd1000; ddv_u = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("partial_no_accept", 64'({rdd_u, rdv_u}), 64'd3);
        @(negedge clk);
        issue(1'b0, 32'd1000, 32'd33);
        wait_idle();

        // Reset in the middle of CALC clears the result outputs.
        @(negedge clk);
        accept(1'b1, 32'hFFFF_FC00, 32'd3, t);
        while (cyc != t + 20) @(negedge clk);
        reset = 1'b1;
        #1;
        check("ready_in_reset", 64'({rdd_s, rdv_s}), 64'd0);
        @(negedge clk);
        check("reset_mid_tvalid", 64'(ov_s), 64'd0);
        check("reset_mid_tdata", out_s, 64'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 64'({rdd_s, rdv_s}), 64'd3);
        repeat (LAT + 2) @(negedge clk);

        // Random operands on both instances.
        for (int n = 0; n < 40; n++) begin
            sgn = 1'($urandom_range(1, 0));
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(5, 0))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(15, 1));
                2:       a = 32'h8000_0000;
                3:       b = 32'hFFFF_FFFF;
                4:       b = b >> $urandom_range(31, 8);
                default: ;
            endcase
            issue(sgn, a, b);
            if ($urandom_range(1, 0) == 1) wait_idle();
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
